// File: rtl/regfile_writeback_arbiter_if.sv
// ============================================================================
// Module      : regfile_writeback_arbiter_if
// Description : Writeback request, reservation and register-file write bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_writeback_arbiter_if #(
    parameter int NUM_REQ     = 3,
    parameter int DATA_WIDTH  = 24,
    parameter int INDEX_WIDTH = 5
);
    localparam int c_ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_NUM_REGS = 2 ** INDEX_WIDTH;

    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ*INDEX_WIDTH-1:0] req_index;
    logic [NUM_REQ*DATA_WIDTH-1:0]  req_data;
    logic                           reserve_valid;
    logic [INDEX_WIDTH-1:0]         reserve_index;
    logic                           write_enable;
    logic [INDEX_WIDTH-1:0]         write_index;
    logic [DATA_WIDTH-1:0]          write_data;
    logic [c_NUM_REGS-1:0]          pending_mask;
    logic [c_ID_WIDTH-1:0]          grant_id;

    modport master (
        output req_valid, req_index, req_data, reserve_valid, reserve_index,
        input  req_ready, write_enable, write_index, write_data, pending_mask, grant_id
    );

    modport slave (
        input  req_valid, req_index, req_data, reserve_valid, reserve_index,
        output req_ready, write_enable, write_index, write_data, pending_mask, grant_id
    );
endinterface

`default_nettype wire

// File: rtl/regfile_writeback_arbiter.sv
// ============================================================================
// Module      : regfile_writeback_arbiter
// Description : Round-robin arbiter for the register-file write port with a
//               registered write stage and a pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_writeback_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int DATA_WIDTH  = 24,
    parameter int INDEX_WIDTH = 5,
    parameter int LONG_BASE   = 28
) (
    input  logic                          clk,
    input  logic                          reset,
    regfile_writeback_arbiter_if.slave    bus
);
    localparam int                     c_ID_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                     c_CAND_WIDTH  = c_ID_WIDTH + 1;
    localparam int                     c_NUM_REGS    = 2 ** INDEX_WIDTH;
    localparam int                     c_SHORT_WIDTH = 16;
    localparam logic [c_ID_WIDTH:0]    c_NUM_REQ_W   = c_CAND_WIDTH'(NUM_REQ);
    localparam logic [c_ID_WIDTH-1:0]  c_LAST_REQ    = c_ID_WIDTH'(NUM_REQ - 1);
    localparam logic [INDEX_WIDTH-1:0] c_LONG_BASE   = INDEX_WIDTH'(LONG_BASE);

    logic [c_ID_WIDTH-1:0]  r_ptr_q,          w_ptr_d;
    logic                   r_write_enable_q, w_write_enable_d;
    logic [INDEX_WIDTH-1:0] r_write_index_q,  w_write_index_d;
    logic [DATA_WIDTH-1:0]  r_write_data_q,   w_write_data_d;
    logic [c_ID_WIDTH-1:0]  r_grant_id_q,     w_grant_id_d;
    logic [c_NUM_REGS-1:0]  r_pending_q,      w_pending_d;

    logic                   w_found;
    logic                   w_xfer;
    logic [c_ID_WIDTH-1:0]  w_gnt;
    logic [c_ID_WIDTH:0]    w_cand;
    logic [NUM_REQ-1:0]     w_req_ready;
    logic [INDEX_WIDTH-1:0] w_sel_index;
    logic [DATA_WIDTH-1:0]  w_sel_data;

    // Search from the pointer; candidate index wraps modulo NUM_REQ.
    always_comb begin : arbitrate
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr_q} + c_CAND_WIDTH'(k);
            if (w_cand >= c_NUM_REQ_W) begin
                w_cand = w_cand - c_NUM_REQ_W;
            end
            if (!w_found && bus.req_valid[w_cand[c_ID_WIDTH-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_cand[c_ID_WIDTH-1:0];
            end
        end
    end

    assign w_xfer      = w_found && !reset;
    assign w_sel_index = bus.req_index[w_gnt*INDEX_WIDTH +: INDEX_WIDTH];
    assign w_sel_data  = bus.req_data[w_gnt*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin : ready_decode
        w_req_ready = '0;
        if (w_xfer) begin
            w_req_ready[w_gnt] = 1'b1;
        end
    end

    always_comb begin : next_state
        w_write_enable_d = w_xfer;
        w_write_index_d  = r_write_index_q;
        w_write_data_d   = r_write_data_q;
        w_grant_id_d     = r_grant_id_q;
        w_ptr_d          = r_ptr_q;
        if (w_xfer) begin
            w_write_index_d = w_sel_index;
            w_grant_id_d    = w_gnt;
            // Short registers only hold 16 bits; the upper bits are forced to zero.
            w_write_data_d  = (w_sel_index >= c_LONG_BASE) ? w_sel_data
                            : {{(DATA_WIDTH-c_SHORT_WIDTH){1'b0}}, w_sel_data[c_SHORT_WIDTH-1:0]};
            w_ptr_d         = (w_gnt == c_LAST_REQ) ? '0 : w_gnt + 1'b1;
        end

        // Clear before set so a same-cycle reservation survives the retiring write.
        w_pending_d = r_pending_q;
        if (r_write_enable_q) begin
            w_pending_d[r_write_index_q] = 1'b0;
        end
        if (bus.reserve_valid) begin
            w_pending_d[bus.reserve_index] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin : state_regs
        if (reset) begin
            r_ptr_q          <= '0;
            r_write_enable_q <= 1'b0;
            r_write_index_q  <= '0;
            r_write_data_q   <= '0;
            r_grant_id_q     <= '0;
            r_pending_q      <= '0;
        end else begin
            r_ptr_q          <= w_ptr_d;
            r_write_enable_q <= w_write_enable_d;
            r_write_index_q  <= w_write_index_d;
            r_write_data_q   <= w_write_data_d;
            r_grant_id_q     <= w_grant_id_d;
            r_pending_q      <= w_pending_d;
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.write_enable = r_write_enable_q;
    assign bus.write_index  = r_write_index_q;
    assign bus.write_data   = r_write_data_q;
    assign bus.grant_id     = r_grant_id_q;
    assign bus.pending_mask = r_pending_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback_arbiter.sv
// ============================================================================
// Module      : tb_regfile_writeback_arbiter
// Description : Directed scoreboard bench for regfile_writeback_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_writeback_arbiter;
    typedef struct {
        logic [4:0]  idx;
        logic [23:0] data;
        logic [1:0]  gid;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   streak;
    int   max_streak;
    int   gcnt[4];
    int   gbase[4];
    exp_t exp_q[$];
    exp_t mon_e;

    regfile_writeback_arbiter_if #(.NUM_REQ(3), .DATA_WIDTH(24), .INDEX_WIDTH(5)) bus ();

    regfile_writeback_arbiter #(
        .NUM_REQ(3), .DATA_WIDTH(24), .INDEX_WIDTH(5), .LONG_BASE(28)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %0s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] idx, input logic [23:0] data);
        bus.req_index[5*i +: 5]   = idx;
        bus.req_data[24*i +: 24]  = data;
    endtask

    task automatic push(input logic [4:0] idx, input logic [23:0] data, input logic [1:0] gid);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        e.gid  = gid;
        exp_q.push_back(e);
    endtask

    // Monitor: every registered write is matched against the oldest expectation.
    always @(negedge clk) begin
        if (bus.write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual_index=%0d actual_data=%h expected=none",
                         bus.write_index, bus.write_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_index", 32'(bus.write_index), 32'(mon_e.idx));
                check("write_data",  32'(bus.write_data),  32'(mon_e.data));
                check("grant_id",    32'(bus.grant_id),    32'(mon_e.gid));
            end
            gcnt[bus.grant_id]++;
            streak++;
            if (streak > max_streak) max_streak = streak;
        end else begin
            streak = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; errors = 0; streak = 0; max_streak = 0;
        for (int i = 0; i < 4; i++) begin gcnt[i] = 0; gbase[i] = 0; end
        reset = 1'b1;
        bus.req_valid = '0; bus.req_index = '0; bus.req_data = '0;
        bus.reserve_valid = 1'b0; bus.reserve_index = '0;

        // Reset and idle
        bus.req_valid = 3'b111;
        #1 check("ready_in_reset", 32'(bus.req_ready), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.req_valid = '0;
        check("rst_we",    32'(bus.write_enable), 32'h0);
        check("rst_widx",  32'(bus.write_index),  32'h0);
        check("rst_wdata", 32'(bus.write_data),   32'h0);
        check("rst_gid",   32'(bus.grant_id),     32'h0);
        check("rst_pend",  bus.pending_mask,      32'h0);
        for (int c = 0; c < 3; c++) begin
            #1 check("idle_ready", 32'(bus.req_ready), 32'h0);
            @(negedge clk);
            check("idle_we",   32'(bus.write_enable), 32'h0);
            check("idle_pend", bus.pending_mask,      32'h0);
        end

        // Short register: zero-extended data
        set_req(0, 5'd5, 24'hABCDEF);
        bus.req_valid = 3'b001;
        #1 check("ready_single", 32'(bus.req_ready), 32'h1);
        push(5'd5, 24'h00CDEF, 2'd0);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        check("pend_stays_clear", bus.pending_mask, 32'h0);

        // Long register: full width
        set_req(1, 5'd30, 24'h123456);
        bus.req_valid = 3'b010;
        #1 check("ready_long", 32'(bus.req_ready), 32'h2);
        push(5'd30, 24'h123456, 2'd1);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        check("we_drops",    32'(bus.write_enable), 32'h0);
        check("wdata_holds", 32'(bus.write_data),   32'h123456);

        // Round-robin fairness from a freshly reset pointer
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_req(0, 5'd1,  24'h111111);
        set_req(1, 5'd29, 24'h222222);
        set_req(2, 5'd3,  24'h333333);
        for (int i = 0; i < 4; i++) gbase[i] = gcnt[i];
        bus.req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            case (k % 3)
                0: begin #1 check("rr_ready", 32'(bus.req_ready), 32'h1); push(5'd1,  24'h001111, 2'd0); end
                1: begin #1 check("rr_ready", 32'(bus.req_ready), 32'h2); push(5'd29, 24'h222222, 2'd1); end
                default: begin #1 check("rr_ready", 32'(bus.req_ready), 32'h4); push(5'd3, 24'h003333, 2'd2); end
            endcase
            @(negedge clk);
        end
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        check("rr_streak", 32'(max_streak), 32'd6);
        check("rr_cnt0", 32'(gcnt[0] - gbase[0]), 32'd2);
        check("rr_cnt1", 32'(gcnt[1] - gbase[1]), 32'd2);
        check("rr_cnt2", 32'(gcnt[2] - gbase[2]), 32'd2);

        // Scoreboard set and clear
        bus.reserve_valid = 1'b1; bus.reserve_index = 5'd7;
        @(negedge clk);
        bus.reserve_valid = 1'b0;
        check("pend_set", bus.pending_mask, 32'h0000_0080);
        repeat (2) @(negedge clk);
        set_req(2, 5'd7, 24'hFEDCBA);
        bus.req_valid = 3'b100;
        #1 check("ready_sb", 32'(bus.req_ready), 32'h4);
        push(5'd7, 24'h00DCBA, 2'd2);
        @(negedge clk);
        bus.req_valid = '0;
        check("pend_during_write", bus.pending_mask, 32'h0000_0080);
        @(negedge clk);
        check("pend_cleared", bus.pending_mask, 32'h0);

        // Reservation in the same cycle as the retiring write wins
        bus.reserve_valid = 1'b1; bus.reserve_index = 5'd7;
        @(negedge clk);
        bus.reserve_valid = 1'b0;
        check("pend_reset_again", bus.pending_mask, 32'h0000_0080);
        set_req(2, 5'd7, 24'h0A0B0C);
        bus.req_valid = 3'b100;
        #1 check("ready_sb2", 32'(bus.req_ready), 32'h4);
        push(5'd7, 24'h000B0C, 2'd2);
        @(negedge clk);
        bus.req_valid = '0;
        bus.reserve_valid = 1'b1; bus.reserve_index = 5'd7;
        @(negedge clk);
        bus.reserve_valid = 1'b0;
        check("pend_reserve_wins", bus.pending_mask, 32'h0000_0080);

        // Reset mid-operation
        set_req(1, 5'd28, 24'hC0FFEE);
        bus.req_valid = 3'b010;
        #1 check("ready_pre_reset", 32'(bus.req_ready), 32'h2);
        push(5'd28, 24'hC0FFEE, 2'd1);
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = 3'b111;
        #1 check("ready_in_reset_mid", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        check("we_after_reset",   32'(bus.write_enable), 32'h0);
        check("pend_after_reset", bus.pending_mask,      32'h0);
        set_req(0, 5'd2, 24'h765432);
        #1 check("grant_after_reset", 32'(bus.req_ready), 32'h1);
        push(5'd2, 24'h005432, 2'd0);
        @(negedge clk);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
